// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BIT   = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    BREAK_WAIT = 3'd5
  } uart_state_e;

  localparam int   DEF_DATA_BITS    = 8;
  localparam int   DEF_OVERSAMPLE   = 16;
  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Nonzero when data bits plus the received parity bit violate the selected mode.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic sample,
                                           input logic odd);
    return (^data) ^ sample ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Synchronizer chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: start/data/parity/stop recovery on a 16x-style oversampling tick,
// with per-byte parity and framing error flags.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int            TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_state_e          state_r;
  uart_state_e          state_nxt_s;
  logic                 rx_s;
  logic [TW-1:0]        tcnt_r;
  logic [2:0]           bcnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_pend_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 rx_busy_r;
  logic [7:0]           data_ext_s;
  logic                 mid_s;
  logic                 end_s;
  logic                 tcnt_clr_s;
  logic                 tcnt_inc_s;
  logic                 bcnt_clr_s;
  logic                 shift_en_s;
  logic                 par_en_s;
  logic                 stop_en_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx_in),
    .q    (rx_s)
  );

  assign mid_s = baud_tick && (tcnt_r == TICK_MID);
  assign end_s = baud_tick && (tcnt_r == TICK_END);

  // Zero-extend the shift register for the 8-bit parity helper.
  always_comb begin
    data_ext_s                = 8'h00;
    data_ext_s[DATA_BITS-1:0] = shift_r;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; all bit-period decisions wait for a baud tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_s) state_nxt_s = START_BIT;
        else       state_nxt_s = IDLE;
      end
      START_BIT: begin
        if (mid_s) state_nxt_s = rx_s ? IDLE : DATA_BIT;
        else       state_nxt_s = START_BIT;
      end
      DATA_BIT: begin
        if (end_s && (bcnt_r == LAST_BIT)) state_nxt_s = PAR_ON ? PARITY_BIT : STOP_BIT;
        else                               state_nxt_s = DATA_BIT;
      end
      PARITY_BIT: begin
        if (end_s) state_nxt_s = STOP_BIT;
        else       state_nxt_s = PARITY_BIT;
      end
      STOP_BIT: begin
        if (end_s) state_nxt_s = rx_s ? IDLE : BREAK_WAIT;
        else       state_nxt_s = STOP_BIT;
      end
      BREAK_WAIT: begin
        if (rx_s) state_nxt_s = IDLE;
        else      state_nxt_s = BREAK_WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    tcnt_clr_s = 1'b0;
    tcnt_inc_s = 1'b0;
    bcnt_clr_s = 1'b0;
    shift_en_s = 1'b0;
    par_en_s   = 1'b0;
    stop_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        tcnt_clr_s = 1'b1;
        bcnt_clr_s = 1'b1;
      end
      START_BIT: begin
        if (mid_s) begin
          tcnt_clr_s = 1'b1;
          bcnt_clr_s = 1'b1;
        end else begin
          tcnt_inc_s = baud_tick;
        end
      end
      DATA_BIT: begin
        if (end_s) begin
          tcnt_clr_s = 1'b1;
          shift_en_s = 1'b1;
        end else begin
          tcnt_inc_s = baud_tick;
        end
      end
      PARITY_BIT: begin
        if (end_s) begin
          tcnt_clr_s = 1'b1;
          par_en_s   = 1'b1;
        end else begin
          tcnt_inc_s = baud_tick;
        end
      end
      STOP_BIT: begin
        if (end_s) begin
          tcnt_clr_s = 1'b1;
          stop_en_s  = 1'b1;
        end else begin
          tcnt_inc_s = baud_tick;
        end
      end
      BREAK_WAIT: begin
        tcnt_clr_s = 1'b1;
      end
      default: begin
        tcnt_clr_s = 1'b1;
        bcnt_clr_s = 1'b1;
      end
    endcase
  end

  // Counters, shift register and registered host-side outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt_r       <= {TW{1'b0}};
      bcnt_r       <= 3'd0;
      shift_r      <= {DATA_BITS{1'b0}};
      perr_pend_r  <= 1'b0;
      rx_data_r    <= {DATA_BITS{1'b0}};
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      rx_busy_r    <= 1'b0;
    end else begin
      if (tcnt_clr_s)      tcnt_r <= {TW{1'b0}};
      else if (tcnt_inc_s) tcnt_r <= tcnt_r + TICK_ONE;
      if (bcnt_clr_s)      bcnt_r <= 3'd0;
      else if (shift_en_s) bcnt_r <= bcnt_r + 3'd1;
      // LSB-first line order: each new bit enters at the MSB and walks down.
      if (shift_en_s) shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      if (par_en_s) perr_pend_r <= parity_mismatch(data_ext_s, rx_s, PAR_ODD);
      rx_valid_r <= stop_en_s;
      if (stop_en_s) begin
        rx_data_r    <= shift_r;
        frame_err_r  <= ~rx_s;
        parity_err_r <= PAR_ON & perr_pend_r;
      end
      rx_busy_r <= (state_nxt_s != IDLE);
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frame-level scoreboard checked every clk plus directed checks.
module tb_uart_rx_fsm;

  localparam int DB   = 8;
  localparam int PE   = 1;
  localparam int PODD = 0;
  localparam int OS   = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          baud_tick;
  logic          rx_in;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  uart_rx_fsm #(
    .DATA_BITS  (DB),
    .PARITY_EN  (PE),
    .PARITY_ODD (PODD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         tick;
  } exp_t;

  exp_t       q[$];
  int         valid_ticks[$];
  int         cnt = 0;
  logic       tick_seen = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, cnt);
    end
  endtask

  // Parity error iff the number of ones over data+parity bit disagrees with the chosen mode.
  function automatic logic model_perr(input logic [7:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    return (ones % 2) != PODD;
  endfunction

  // Baud tick: one clk high out of every four.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    tick_seen <= baud_tick;
    if (baud_tick) cnt <= cnt + 1;
  end

  // Compare process: every clk, checks valid timing, payload and held data against the scoreboard.
  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_data = 8'h00;
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
      end else begin
        exp_v = (q.size() > 0) && tick_seen && (cnt == q[0].tick);
        chk("valid", {31'd0, rx_valid}, {31'd0, exp_v});
        if (exp_v) begin
          chk("data", {24'd0, rx_data}, {24'd0, q[0].data});
          chk("perr", {31'd0, parity_err}, {31'd0, q[0].perr});
          chk("ferr", {31'd0, frame_err}, {31'd0, q[0].ferr});
          last_data = q[0].data;
          valid_ticks.push_back(cnt);
          void'(q.pop_front());
        end else begin
          chk("hold_data", {24'd0, rx_data}, {24'd0, last_data});
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick) k++;
    end
    #1;
  endtask

  // Drives one frame; expected result is due at the middle of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = (PE != 0) ? model_perr(d, pbit) : 1'b0;
    e.ferr = ~stop;
    e.tick = cnt + OS * (1 + DB + PE) + OS / 2;
    q.push_back(e);
    rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx_in = d[i];
      wait_ticks(OS);
    end
    if (PE != 0) begin
      rx_in = pbit;
      wait_ticks(OS);
    end
    rx_in = stop;
    wait_ticks(OS);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nv;
    rstn  = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    rstn = 1'b1;
    wait_ticks(4);

    chk("model_a5", {31'd0, model_perr(8'hA5, 1'b0)}, 32'd0);
    chk("model_01", {31'd0, model_perr(8'h01, 1'b0)}, 32'd1);

    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(4);
    chk("a5_held", {24'd0, rx_data}, 32'hA5);
    chk("a5_perr", {31'd0, parity_err}, 32'd0);

    send_frame(8'h01, 1'b0, 1'b1);
    wait_ticks(4);
    chk("01_perr", {31'd0, parity_err}, 32'd1);
    chk("01_ferr", {31'd0, frame_err}, 32'd0);

    // Break: stop bit low and the line stays low for 40 ticks in total.
    nv = valid_ticks.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(24);
    chk("break_busy", {31'd0, rx_busy}, 32'd1);
    chk("break_ferr", {31'd0, frame_err}, 32'd1);
    rx_in = 1'b1;
    wait_ticks(2);
    chk("break_idle", {31'd0, rx_busy}, 32'd0);
    chk("break_one_valid", valid_ticks.size(), nv + 1);
    wait_ticks(4);

    // Glitch: 4 ticks low is rejected at the start-bit midpoint.
    nv = valid_ticks.size();
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    wait_ticks(8);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    wait_ticks(20);
    chk("glitch_no_valid", valid_ticks.size(), nv);

    // Back-to-back frames with no idle gap; 11-bit frames are 176 ticks apart.
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_ticks(4);
    if (valid_ticks.size() >= 2)
      chk("b2b_spacing", valid_ticks[valid_ticks.size()-1] - valid_ticks[valid_ticks.size()-2], 32'd176);
    else
      chk("b2b_count", valid_ticks.size(), 32'd2);
    chk("b2b_data", {24'd0, rx_data}, 32'hC3);

    // Reset in the middle of data bit 3 of 0xFF, then a clean 0x55 frame.
    nv = valid_ticks.size();
    rx_in = 1'b0;
    wait_ticks(OS);
    rx_in = 1'b1;
    wait_ticks(3 * OS + 6);
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("mid_rst_perr", {31'd0, parity_err}, 32'd0);
    wait_ticks(3);
    rstn = 1'b1;
    wait_ticks(4);
    chk("mid_rst_no_valid", valid_ticks.size(), nv);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_ticks(4);
    chk("post_rst_data", {24'd0, rx_data}, 32'h55);
    chk("post_rst_count", valid_ticks.size(), nv + 1);

    wait_ticks(20);
    chk("pending", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
